// File: rtl/dma_pkg.sv
// Shared DMA constants and small types used by the FIFO and the DMA master blocks.
package dma_pkg;

  localparam int DMA_DATA_W   = 32;
  localparam int DMA_ADDR_W   = 8;
  localparam int DMA_AF_LEVEL = 2**(DMA_ADDR_W-1);
  localparam int DMA_AE_LEVEL = 4;

  // Sticky error flags; both clear only on flush or reset.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/dma_fifo_if.sv
// FIFO handshake bundle: master drives requests/data, slave (the FIFO) drives status.
interface dma_fifo_if import dma_pkg::*; #(
  parameter int DATA_W = DMA_DATA_W,
  parameter int ADDR_W = DMA_ADDR_W
);
  logic              FF_clear;
  logic              FF_writerequest;
  logic [DATA_W-1:0] FF_data;
  logic              FF_readrequest;
  logic [DATA_W-1:0] FF_q;
  logic              FF_empty;
  logic              FF_full;
  logic              FF_almostfull;
  logic              FF_almostempty;
  logic [ADDR_W:0]   FF_usedw;
  logic              FF_overflow;
  logic              FF_underflow;

  modport master (
    output FF_clear, FF_writerequest, FF_data, FF_readrequest,
    input  FF_q, FF_empty, FF_full, FF_almostfull, FF_almostempty,
           FF_usedw, FF_overflow, FF_underflow
  );

  modport slave (
    input  FF_clear, FF_writerequest, FF_data, FF_readrequest,
    output FF_q, FF_empty, FF_full, FF_almostfull, FF_almostempty,
           FF_usedw, FF_overflow, FF_underflow
  );
endinterface

// File: rtl/dma_fifo_ram.sv
// Storage for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module dma_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              iClk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store on the rising edge when enabled.
  always_ff @(posedge iClk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dma_fifo.sv
// Show-ahead synchronous FIFO with registered fill count, level flags and sticky errors.
module dma_fifo import dma_pkg::*; #(
  parameter int DATA_W   = DMA_DATA_W,
  parameter int ADDR_W   = DMA_ADDR_W,
  parameter int AF_LEVEL = 2**(ADDR_W-1),
  parameter int AE_LEVEL = DMA_AE_LEVEL
) (
  input  logic iClk,
  input  logic iReset_n,
  dma_fifo_if.slave ff
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("dma_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
    $error("dma_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [ADDR_W:0]   wr_ptr, rd_ptr, usedw;
  fifo_err_t         err;
  logic              empty, full, wr_acc, rd_acc, ram_we;
  logic [DATA_W-1:0] ram_q;

  // Extra wrap bit distinguishes full from empty when indices coincide.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  // Flush wins over both requests; a full FIFO rejects writes even when a pop frees a slot.
  assign wr_acc = ff.FF_writerequest & ~full & ~ff.FF_clear;
  assign rd_acc = ff.FF_readrequest & ~empty & ~ff.FF_clear;
  // No store on an edge where reset is asserted.
  assign ram_we = wr_acc & iReset_n;

  dma_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .iClk  (iClk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (ff.FF_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Pointer advance on accepted transfers, flush returns both to zero.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (ff.FF_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Fill count tracks the pointers on the same edge; read+write leaves it unchanged.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      usedw <= '0;
    end else if (ff.FF_clear) begin
      usedw <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   usedw <= usedw + PTR_ONE;
        2'b01:   usedw <= usedw - PTR_ONE;
        default: usedw <= usedw;
      endcase
    end
  end

  // Sticky error capture on any request against the wrong boundary.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      err <= '0;
    end else if (ff.FF_clear) begin
      err <= '0;
    end else begin
      err.overflow  <= err.overflow  | (ff.FF_writerequest & full);
      err.underflow <= err.underflow | (ff.FF_readrequest & empty);
    end
  end

  assign ff.FF_q           = empty ? '0 : ram_q;
  assign ff.FF_empty       = empty;
  assign ff.FF_full        = full;
  assign ff.FF_usedw       = usedw;
  assign ff.FF_almostfull  = (usedw >= AF_L);
  assign ff.FF_almostempty = (usedw <= AE_L);
  assign ff.FF_overflow    = err.overflow;
  assign ff.FF_underflow   = err.underflow;
endmodule

// File: doc/dma_fifo.md
DMA_FIFO -- requirements
Module: dma_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter AF_LEVEL, default 2**(ADDR_W-1), almost-full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold in words.
REQ-005 SHALL have port iClk  input  1  rising-edge clock.
REQ-006 SHALL have port iReset_n  input  1  reset, asynchronous, active-low; clock iClk.
REQ-007 SHALL have port FF_clear  input  1  synchronous flush, one-cycle pulse.
REQ-008 SHALL have port FF_writerequest  input  1  write strobe.
REQ-009 SHALL have port FF_data  input  DATA_W  write data.
REQ-010 SHALL have port FF_readrequest  input  1  read/pop strobe.
REQ-011 SHALL have port FF_q  output  DATA_W  show-ahead head-of-queue word.
REQ-012 SHALL have port FF_empty  output  1  no words stored.
REQ-013 SHALL have port FF_full  output  1  DEPTH words stored.
REQ-014 SHALL have port FF_almostfull  output  1  usedw >= AF_LEVEL.
REQ-015 SHALL have port FF_almostempty  output  1  usedw <= AE_LEVEL.
REQ-016 SHALL have port FF_usedw  output  ADDR_W+1  stored word count, 0..DEPTH.
REQ-017 SHALL have port FF_overflow  output  1  sticky: write attempted while full.
REQ-018 SHALL have port FF_underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 Read and write pointers SHALL be ADDR_W+1 bits; MSB is wrap bit; index = low ADDR_W bits; increment modulo 2**(ADDR_W+1).
REQ-020 Write accepted iff FF_writerequest & ~FF_full; data stored at wr index on that rising edge; wr pointer +1.
REQ-021 Read accepted iff FF_readrequest & ~FF_empty; rd pointer +1 on that edge.
REQ-022 FF_q SHALL equal the word at rd index combinationally (zero read latency); FF_q SHALL be 0 while FF_empty.
REQ-023 Written word SHALL appear on FF_q the cycle after the write edge if FIFO was empty.
REQ-024 Simultaneous accepted read and write SHALL leave FF_usedw unchanged; both pointers advance.
REQ-025 When full, write SHALL be rejected even if a read is accepted the same cycle; the read still completes.
REQ-026 FF_empty = (wr ptr == rd ptr); FF_full = (index equal, wrap bits differ).
REQ-027 FF_usedw SHALL be registered, updated +1/-1/0 per accepted write/read in the same edge as the pointers; all flags consistent with FF_usedw every cycle.
REQ-028 FF_overflow set on any cycle FF_writerequest & FF_full; FF_underflow set on FF_readrequest & FF_empty; both hold until FF_clear or reset.
REQ-029 FF_clear SHALL take priority over reads/writes in the same cycle: pointers, FF_usedw, sticky flags -> 0; the concurrent write is discarded.
REQ-030 AF_LEVEL SHALL satisfy 1..DEPTH and AE_LEVEL 0..DEPTH-1; violation is an elaboration error.

Reset
REQ-031 On iReset_n low: pointers 0, FF_usedw 0, FF_empty 1, FF_full 0, FF_almostfull 0, FF_almostempty 1, FF_overflow 0, FF_underflow 0, FF_q 0.
REQ-032 Storage array SHALL NOT be reset; reset mid-transfer SHALL discard all stored words with no further writes that edge.

Structure
REQ-033 Package dma_pkg SHALL hold default DATA_W, ADDR_W, AF_LEVEL, AE_LEVEL constants shared with DMA master read/write blocks.
REQ-034 Storage SHALL be sub-module dma_fifo_ram: 1 write port (sync), 1 read port (async), DATA_W x DEPTH, no reset.

Verification (DATA_W=32, ADDR_W=4, AF_LEVEL=12, AE_LEVEL=2)
REQ-035 Reset, then write 0x11..0x1F, 0x20 (16 words) -> FF_full=1, FF_usedw=16, FF_almostfull from usedw=12; 17th write -> FF_overflow=1, usedw stays 16.
REQ-036 Drain 16 words -> FF_q sequence 0x11..0x20 in order, FF_empty=1 after last pop; extra pop -> FF_underflow=1, FF_q=0.
REQ-037 Fill 8, then 40 cycles simultaneous read+write with incrementing data -> FF_usedw=8 constant, data order preserved across pointer wrap.
REQ-038 Full FIFO, read+write same cycle -> read completes, write rejected, FF_usedw=15, FF_overflow=1.
REQ-039 usedw=5 with sticky flags set, pulse FF_clear together with writerequest -> next cycle usedw=0, FF_empty=1, both sticky flags 0.
REQ-040 Assert iReset_n low asynchronously mid-burst (usedw=9) -> outputs reach REQ-031 values before next clock edge.
